// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock, LSB first,
// with a single full-adder slice and registered carry, producing ARM-style NZCV flags.
module serial_subtractor #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-2:0] shift;
    logic             carry;
    logic             a_sign;
    logic             b_sign;
    logic [CW-1:0]    count;

    logic             load;
    logic             last;
    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH-1:0] final_result;

    // The subtrahend is inverted and the carry seeded with 1 at load, giving a + ~b + 1.
    always_comb begin
        load         = ((state == IDLE) || (state == DONE)) && start;
        last         = (state == BUSY) && (count == CW'(WIDTH - 1));
        sum_bit      = sa[0] ^ ~sb[0] ^ carry;
        carry_next   = (sa[0] & ~sb[0]) | (sa[0] & carry) | (~sb[0] & carry);
        final_result = {sum_bit, shift};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last) state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy = (state == BUSY);
    assign done = (state == DONE);

    // Visible result and flags change only when the last bit completes, so the
    // previous answer stays readable throughout the next operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            sa        <= '0;
            sb        <= '0;
            shift     <= '0;
            carry     <= 1'b0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
            count     <= '0;
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (load) begin
            sa     <= a;
            sb     <= b;
            carry  <= 1'b1;
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
            count  <= '0;
        end else if (state == BUSY) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            carry <= carry_next;
            shift <= final_result[WIDTH-1:1];
            count <= count + CW'(1);
            if (last) begin
                result    <= final_result;
                negative  <= sum_bit;
                zero      <= (final_result == '0);
                carry_out <= carry_next;
                overflow  <= (a_sign ^ b_sign) & (sum_bit ^ a_sign);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases on an 8-bit instance and
// randomized back-to-back operations on a 64-bit instance against an arithmetic model.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  result8;
    logic        negative8;
    logic        zero8;
    logic        carry8;
    logic        overflow8;
    logic        start64;
    logic [63:0] a64;
    logic [63:0] b64;
    logic        busy64;
    logic        done64;
    logic [63:0] result64;
    logic        negative64;
    logic        zero64;
    logic        carry64;
    logic        overflow64;

    int checks   = 0;
    int failures = 0;
    bit use64    = 1'b0;

    logic [63:0] cur_result;
    logic        cur_busy;
    logic        cur_done;
    logic [3:0]  cur_flags;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .negative(negative8),
        .zero(zero8), .carry_out(carry8), .overflow(overflow8)
    );

    serial_subtractor #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .a(a64), .b(b64),
        .busy(busy64), .done(done64), .result(result64), .negative(negative64),
        .zero(zero64), .carry_out(carry64), .overflow(overflow64)
    );

    always_comb begin
        cur_result = use64 ? result64 : {56'd0, result8};
        cur_busy   = use64 ? busy64 : busy8;
        cur_done   = use64 ? done64 : done8;
        cur_flags  = use64 ? {negative64, zero64, carry64, overflow64}
                           : {negative8, zero8, carry8, overflow8};
    end

    // Reference: plain modular subtraction and unsigned/signed comparisons; returns {N,Z,C,V,result}.
    function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [63:0] res;
        logic        n;
        logic        z;
        logic        c;
        logic        v;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = b & mask;
        res  = (am - bm) & mask;
        n    = res[w-1];
        z    = (res == 64'd0);
        c    = (am >= bm);
        v    = (am[w-1] != bm[w-1]) && (res[w-1] != am[w-1]);
        return {n, z, c, v, res};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b);
        if (use64) begin
            start64 = 1'b1;
            a64     = a;
            b64     = b;
        end else begin
            start8 = 1'b1;
            a8     = a[7:0];
            b8     = b[7:0];
        end
    endtask

    task automatic clearStart();
        start8  = 1'b0;
        start64 = 1'b0;
    endtask

    // Called on the negedge of the accepting cycle; returns on the negedge where done is seen.
    task automatic waitResult(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input bit hold_check, input logic [63:0] hold_val,
                              input int inject_at, input logic [63:0] ia, input logic [63:0] ib);
        int          w;
        int          lat;
        int          busy_cycles;
        logic [67:0] exp;
        w           = use64 ? 64 : 8;
        lat         = 1;
        busy_cycles = 0;
        exp         = model(a, b, w);
        @(negedge clk);
        clearStart();
        while (!cur_done && lat < w + 5) begin
            if (cur_busy) busy_cycles++;
            if (hold_check) checkOutput({tag, "_hold"}, cur_result, hold_val);
            if (lat == inject_at) applyStimulus(ia, ib);
            @(negedge clk);
            clearStart();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'(w + 1));
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(w));
        checkOutput({tag, "_busy_with_done"}, 64'(cur_busy), 64'd0);
        checkOutput({tag, "_result"}, cur_result, exp[63:0]);
        checkOutput({tag, "_nzcv"}, 64'(cur_flags), 64'(exp[67:64]));
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 64'(cur_done), 64'd0);
        checkOutput({tag, "_idle_busy"}, 64'(cur_busy), 64'd0);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("[TB] FAIL watchdog simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [7:0]  da [5];
        logic [7:0]  db [5];
        logic [7:0]  dr [5];
        logic [63:0] ra;
        logic [63:0] rb;
        logic [63:0] prev;
        logic [67:0] exp;
        int          seen;

        da = '{8'h05, 8'h2A, 8'h00, 8'h80, 8'h7F};
        db = '{8'h03, 8'h2A, 8'h01, 8'h01, 8'hFF};
        dr = '{8'h02, 8'h00, 8'hFF, 8'h7F, 8'h80};

        reset = 1'b1;
        clearStart();
        a8 = '0; b8 = '0; a64 = '0; b64 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset8_outputs", {busy8, done8, result8, negative8, zero8, carry8, overflow8}, 64'd0);
        checkOutput("reset64_outputs", 64'({busy64, done64, negative64, zero64, carry64, overflow64}), 64'd0);
        checkOutput("reset64_result", result64, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed 8-bit cases");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(64'(da[i]), 64'(db[i]));
            waitResult($sformatf("dir%0d", i), 64'(da[i]), 64'(db[i]), 1'b0, 64'd0, -1, 64'd0, 64'd0);
            checkOutput($sformatf("dir%0d_const", i), cur_result, 64'(dr[i]));
            checkIdle($sformatf("dir%0d", i));
        end

        applyStimulus(64'h05, 64'h03);
        waitResult("ignore_start", 64'h05, 64'h03, 1'b1, 64'h80, 3, 64'h10, 64'h01);
        checkIdle("ignore_start");

        applyStimulus(64'h30, 64'h10);
        waitResult("b2b_first", 64'h30, 64'h10, 1'b0, 64'd0, -1, 64'd0, 64'd0);
        applyStimulus(64'h01, 64'h02);
        waitResult("b2b_second", 64'h01, 64'h02, 1'b1, 64'h20, -1, 64'd0, 64'd0);
        checkIdle("b2b_second");

        applyStimulus(64'h44, 64'h11);
        @(negedge clk);
        clearStart();
        repeat (3) @(negedge clk);
        checkOutput("midop_busy_before_reset", 64'(cur_busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midop_reset_outputs", {55'd0, busy8, done8, result8, negative8, zero8, carry8, overflow8}, 64'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (cur_done || cur_busy) seen++;
        end
        checkOutput("midop_no_done_after_reset", 64'(seen), 64'd0);
        applyStimulus(64'h44, 64'h11);
        waitResult("after_reset", 64'h44, 64'h11, 1'b1, 64'd0, -1, 64'd0, 64'd0);
        checkIdle("after_reset");

        reset = 1'b1;
        applyStimulus(64'h09, 64'h01);
        @(negedge clk);
        clearStart();
        reset = 1'b0;
        checkOutput("reset_wins_busy", 64'(cur_busy), 64'd0);
        checkOutput("reset_wins_result", cur_result, 64'd0);
        @(negedge clk);
        checkOutput("reset_wins_later_busy", 64'(cur_busy), 64'd0);

        $display("[TB] randomized 64-bit back-to-back operations");
        use64 = 1'b1;
        prev  = 64'd0;
        ra    = {$urandom, $urandom};
        rb    = {$urandom, $urandom};
        applyStimulus(ra, rb);
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ca;
            logic [63:0] cb;
            ca = ra;
            cb = rb;
            waitResult($sformatf("rand%0d", i), ca, cb, 1'b1, prev, -1, 64'd0, 64'd0);
            exp  = model(ca, cb, 64);
            prev = exp[63:0];
            if (i < 999) begin
                ra = {$urandom, $urandom};
                rb = (i % 10 == 3) ? ra : {$urandom, $urandom};
                if (i % 10 == 7) rb[63] = ~ra[63];
                applyStimulus(ra, rb);
            end
        end
        checkIdle("rand_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
